// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Brief    : EX operand forwarding plus load-use / memory-freeze / branch-flush
//            pipeline control for the 5-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int DATA_W       = 16,
    parameter int RADDR_W      = 4,
    parameter int NUM_SRC      = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*RADDR_W-1:0] id_src_num,
    input  logic [NUM_SRC-1:0]         id_src_use,
    input  logic [NUM_SRC*RADDR_W-1:0] ex_src_num,
    input  logic [NUM_SRC*DATA_W-1:0]  ex_src_val,
    input  logic [RADDR_W-1:0]         ex_dst_num,
    input  logic                       ex_mem_read,
    input  logic [RADDR_W-1:0]         mem_dst_num,
    input  logic                       mem_reg_write,
    input  logic [DATA_W-1:0]          mem_val,
    input  logic [RADDR_W-1:0]         wb_dst_num,
    input  logic                       wb_reg_write,
    input  logic [DATA_W-1:0]          wb_val,
    input  logic                       branch_taken,
    input  logic                       mem_busy,
    output logic [NUM_SRC*DATA_W-1:0]  fwd_val,
    output logic [NUM_SRC*2-1:0]       fwd_sel,
    output logic                       pc_en,
    output logic                       fd_en,
    output logic                       de_en,
    output logic                       em_en,
    output logic                       fd_flush,
    output logic                       de_bubble,
    output logic                       mw_bubble,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_mem_wait = 2'd1;
    localparam logic [1:0] c_st_flush    = 2'd2;

    localparam logic [2:0] c_flush_load  = 3'(FLUSH_CYCLES - 1);
    localparam bit         c_multi_flush = (FLUSH_CYCLES > 1);

    logic [1:0]       r_state;
    logic [2:0]       r_flush_ctr;
    logic             r_pend_br;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0]       w_state_nxt;
    logic [2:0]       w_ctr_nxt;
    logic             w_pend_nxt;
    logic             w_load_use;
    logic             w_stall_evt;

    // ------------------------------------------------------------------------
    // Forwarding: MEM result wins over WB, otherwise the register-file value.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        logic [RADDR_W-1:0] w_src;
        logic               w_mem_hit;
        logic               w_wb_hit;

        assign w_src     = ex_src_num[gi*RADDR_W +: RADDR_W];
        assign w_mem_hit = mem_reg_write && (mem_dst_num == w_src);
        assign w_wb_hit  = wb_reg_write && (wb_dst_num == w_src);

        assign fwd_val[gi*DATA_W +: DATA_W] = w_mem_hit ? mem_val :
                                              w_wb_hit  ? wb_val  :
                                              ex_src_val[gi*DATA_W +: DATA_W];
        assign fwd_sel[gi*2 +: 2]           = w_mem_hit ? 2'b10 :
                                              w_wb_hit  ? 2'b01 : 2'b00;
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_read && id_src_use[i] &&
                (id_src_num[i*RADDR_W +: RADDR_W] == ex_dst_num)) begin
                w_load_use = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control decode and next-state
    // ------------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        de_en       = 1'b1;
        em_en       = 1'b1;
        fd_flush    = 1'b0;
        de_bubble   = 1'b0;
        mw_bubble   = 1'b0;
        w_state_nxt = r_state;
        w_ctr_nxt   = r_flush_ctr;
        w_pend_nxt  = r_pend_br;

        case (r_state)
            c_st_run: begin
                if (mem_busy) begin
                    {pc_en, fd_en, de_en, em_en} = 4'b0000;
                    mw_bubble   = 1'b1;
                    w_state_nxt = c_st_mem_wait;
                    w_pend_nxt  = branch_taken;
                end else if (branch_taken) begin
                    fd_flush    = 1'b1;
                    de_bubble   = 1'b1;
                    w_ctr_nxt   = c_flush_load;
                    w_state_nxt = c_multi_flush ? c_st_flush : c_st_run;
                end else if (w_load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    de_bubble = 1'b1;
                end
            end

            c_st_mem_wait: begin
                if (mem_busy) begin
                    {pc_en, fd_en, de_en, em_en} = 4'b0000;
                    mw_bubble = 1'b1;
                    if (branch_taken) begin
                        w_pend_nxt = 1'b1;
                    end
                end else if (r_pend_br || (branch_taken && (r_flush_ctr == 3'd0))) begin
                    fd_flush    = 1'b1;
                    de_bubble   = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_ctr_nxt   = c_flush_load;
                    w_state_nxt = c_multi_flush ? c_st_flush : c_st_run;
                end else if (r_flush_ctr != 3'd0) begin
                    // Resume a flush that was interrupted by the memory stall
                    fd_flush    = 1'b1;
                    de_bubble   = 1'b1;
                    w_ctr_nxt   = r_flush_ctr - 3'd1;
                    w_state_nxt = (r_flush_ctr == 3'd1) ? c_st_run : c_st_flush;
                end else begin
                    w_state_nxt = c_st_run;
                    if (w_load_use) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        de_bubble = 1'b1;
                    end
                end
            end

            c_st_flush: begin
                if (mem_busy) begin
                    {pc_en, fd_en, de_en, em_en} = 4'b0000;
                    mw_bubble   = 1'b1;
                    w_state_nxt = c_st_mem_wait;
                end else begin
                    // EX holds a bubble here, so branch_taken is not acted on
                    fd_flush    = 1'b1;
                    de_bubble   = 1'b1;
                    w_ctr_nxt   = r_flush_ctr - 3'd1;
                    w_state_nxt = (r_flush_ctr == 3'd1) ? c_st_run : c_st_flush;
                end
            end

            default: begin
                w_state_nxt = c_st_run;
                w_ctr_nxt   = 3'd0;
                w_pend_nxt  = 1'b0;
            end
        endcase

        if (reset) begin
            {pc_en, fd_en, de_en, em_en}      = 4'b1111;
            {fd_flush, de_bubble, mw_bubble}  = 3'b000;
        end
    end

    assign w_stall_evt = !pc_en || fd_flush || de_bubble;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_run;
            r_flush_ctr <= 3'd0;
            r_pend_br   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_ctr <= w_ctr_nxt;
            r_pend_br   <= w_pend_nxt;
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_ctrl
// Brief    : Scoreboard bench for hazard_forward_ctrl with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NS = 2;
    localparam int FC = 3;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS*AW-1:0]  id_src_num;
    logic [NS-1:0]     id_src_use;
    logic [NS*AW-1:0]  ex_src_num;
    logic [NS*DW-1:0]  ex_src_val;
    logic [AW-1:0]     ex_dst_num;
    logic              ex_mem_read;
    logic [AW-1:0]     mem_dst_num;
    logic              mem_reg_write;
    logic [DW-1:0]     mem_val;
    logic [AW-1:0]     wb_dst_num;
    logic              wb_reg_write;
    logic [DW-1:0]     wb_val;
    logic              branch_taken;
    logic              mem_busy;
    logic [NS*DW-1:0]  fwd_val;
    logic [NS*2-1:0]   fwd_sel;
    logic              pc_en, fd_en, de_en, em_en;
    logic              fd_flush, de_bubble, mw_bubble;
    logic [CW-1:0]     stall_cnt;

    hazard_forward_ctrl #(
        .DATA_W(DW), .RADDR_W(AW), .NUM_SRC(NS), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .id_src_num(id_src_num), .id_src_use(id_src_use),
        .ex_src_num(ex_src_num), .ex_src_val(ex_src_val),
        .ex_dst_num(ex_dst_num), .ex_mem_read(ex_mem_read),
        .mem_dst_num(mem_dst_num), .mem_reg_write(mem_reg_write), .mem_val(mem_val),
        .wb_dst_num(wb_dst_num), .wb_reg_write(wb_reg_write), .wb_val(wb_val),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .fwd_val(fwd_val), .fwd_sel(fwd_sel),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
        .fd_flush(fd_flush), .de_bubble(de_bubble), .mw_bubble(mw_bubble),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*DW-1:0] fv;
        logic [NS*2-1:0]  fs;
        logic [6:0]       ctl;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: flush cycles still owed, pending branch, frozen last cycle
    int   m_flush_left = 0;
    bit   m_pend       = 1'b0;
    bit   m_frozen     = 1'b0;
    int   m_cnt        = 0;

    task automatic step();
        exp_t            e;
        bit              pc, fd, de, em, ff, db, mb, lu;
        logic [AW-1:0]   src;
        pc = 1; fd = 1; de = 1; em = 1; ff = 0; db = 0; mb = 0; lu = 0;
        for (int i = 0; i < NS; i++) begin
            src = ex_src_num[i*AW +: AW];
            if (mem_reg_write && mem_dst_num == src) begin
                e.fv[i*DW +: DW] = mem_val;  e.fs[i*2 +: 2] = 2'b10;
            end else if (wb_reg_write && wb_dst_num == src) begin
                e.fv[i*DW +: DW] = wb_val;   e.fs[i*2 +: 2] = 2'b01;
            end else begin
                e.fv[i*DW +: DW] = ex_src_val[i*DW +: DW]; e.fs[i*2 +: 2] = 2'b00;
            end
            if (ex_mem_read && id_src_use[i] && id_src_num[i*AW +: AW] == ex_dst_num)
                lu = 1;
        end
        e.cnt = m_cnt[CW-1:0];
        if (reset) begin
            m_flush_left = 0; m_pend = 0; m_frozen = 0; m_cnt = 0;
        end else begin
            if (mem_busy) begin
                pc = 0; fd = 0; de = 0; em = 0; mb = 1;
                if (branch_taken && !(m_flush_left > 0 && !m_frozen)) m_pend = 1;
                m_frozen = 1;
            end else begin
                if (m_pend || (branch_taken && m_flush_left == 0)) begin
                    ff = 1; db = 1; m_flush_left = FC - 1; m_pend = 0;
                end else if (m_flush_left > 0) begin
                    ff = 1; db = 1; m_flush_left = m_flush_left - 1;
                end else if (lu) begin
                    pc = 0; fd = 0; db = 1;
                end
                m_frozen = 0;
            end
            if (!pc || ff || db) m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
        end
        e.ctl = {pc, fd, de, em, ff, db, mb};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {pc_en, fd_en, de_en, em_en, fd_flush, de_bubble, mw_bubble};
            tests++;
            if (fwd_val !== e.fv || fwd_sel !== e.fs) begin
                fails++;
                $display("FAIL fwd t=%0t: val=%h sel=%b, expected val=%h sel=%b",
                         $time, fwd_val, fwd_sel, e.fv, e.fs);
            end
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL ctrl t=%0t: {pc,fd,de,em,ff,db,mb}=%b, expected %b",
                         $time, act, e.ctl);
            end
            tests++;
            if (stall_cnt !== e.cnt) begin
                fails++;
                $display("FAIL stall_cnt t=%0t: got %0d, expected %0d", $time, stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        reset = 1; id_src_num = '0; id_src_use = '0; ex_src_num = '0; ex_src_val = '0;
        ex_dst_num = '0; ex_mem_read = 0; mem_dst_num = '0; mem_reg_write = 0; mem_val = '0;
        wb_dst_num = '0; wb_reg_write = 0; wb_val = '0; branch_taken = 0; mem_busy = 0;
        @(posedge clk); #1;
        step();
        reset = 0;

        // Forward priority
        ex_src_num = {4'd0, 4'd3}; ex_src_val = {16'hbbbb, 16'haaaa};
        mem_dst_num = 4'd3; mem_reg_write = 1; mem_val = 16'h1111;
        wb_dst_num  = 4'd3; wb_reg_write  = 1; wb_val  = 16'h2222;
        step(); mem_reg_write = 0; step(); wb_reg_write = 0; step();

        // Load-use, then same hazard with the operand unused
        ex_mem_read = 1; ex_dst_num = 4'd5; id_src_num = {4'd5, 4'd0}; id_src_use = 2'b10;
        step(); ex_mem_read = 0; step();
        id_src_use = 2'b00; ex_mem_read = 1; step(); ex_mem_read = 0; step();

        // Memory freeze
        mem_busy = 1; repeat (3) step(); mem_busy = 0; step();

        // Branch flush with a second (ignored) branch in cycle 2
        branch_taken = 1; step(); step(); branch_taken = 0; repeat (3) step();

        // Branch and busy together
        branch_taken = 1; mem_busy = 1; step(); branch_taken = 0; step();
        mem_busy = 0; repeat (4) step();

        // Reset mid-flush
        branch_taken = 1; step(); branch_taken = 0; step();
        reset = 1; step(); reset = 0; repeat (2) step();

        // Counter saturation
        ex_mem_read = 1; ex_dst_num = 4'd5; id_src_use = 2'b10;
        repeat (20) step(); ex_mem_read = 0; step();

        // Randomized traffic
        repeat (3000) begin
            reset         = ($urandom_range(0, 63) == 0);
            mem_busy      = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            id_src_use    = 2'($urandom);
            id_src_num    = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            ex_src_num    = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            ex_dst_num    = 4'($urandom_range(0, 3));
            mem_dst_num   = 4'($urandom_range(0, 3));
            wb_dst_num    = 4'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            wb_reg_write  = 1'($urandom);
            mem_val       = 16'($urandom);
            wb_val        = 16'($urandom);
            ex_src_val    = 32'($urandom);
            step();
        end

        @(negedge clk); #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
